// File: rtl/enable_hold_pkg.sv
// Shared types and helpers for the multi-channel enable/hold block.
// Consumers can use hold_status_t to bundle per-lane status bits.
package enable_hold_pkg;

    typedef struct packed {
        logic valid;
        logic changed;
        logic stale;
    } hold_status_t;

    // Largest value an age counter of the given width can hold.
    function automatic longint unsigned age_max(input int unsigned aw);
        return (64'd1 << aw) - 64'd1;
    endfunction

endpackage

// File: rtl/enable_hold_channel.sv
// One lane: captures on en, holds otherwise, and tracks validity,
// saturating age, staleness and a change pulse.
module enable_hold_channel
    import enable_hold_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       REGISTERED  = 0,
    parameter int unsigned       AGE_WIDTH   = 8,
    parameter int unsigned       STALE_LIMIT = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out,
    output hold_status_t         status,
    output logic [AGE_WIDTH-1:0] age
);

    localparam logic [AGE_WIDTH-1:0] AGE_MAX =
        AGE_WIDTH'(age_max(AGE_WIDTH));
    localparam logic STALE_EN = (STALE_LIMIT != 0);

    logic [WIDTH-1:0]     held;
    logic                 held_valid;
    logic [AGE_WIDTH-1:0] age_q;
    logic [AGE_WIDTH-1:0] age_inc;
    logic                 changed_q;
    logic                 stale_q;

    function automatic logic stale_of(input logic [AGE_WIDTH-1:0] a);
        return STALE_EN && (64'(a) >= 64'(STALE_LIMIT));
    endfunction

    // Saturating increment so a long-idle lane never looks fresh again.
    always_comb begin
        age_inc = age_q;
        if (age_q != AGE_MAX) begin
            age_inc = age_q + AGE_WIDTH'(1);
        end
    end

    // Lane state: clear wins over en, en captures, otherwise age ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            held       <= RESET_VALUE;
            held_valid <= 1'b0;
            age_q      <= AGE_MAX;
            changed_q  <= 1'b0;
            stale_q    <= STALE_EN;
        end else if (clear) begin
            held       <= RESET_VALUE;
            held_valid <= 1'b0;
            age_q      <= AGE_MAX;
            changed_q  <= 1'b0;
            stale_q    <= STALE_EN;
        end else if (en) begin
            held       <= in;
            held_valid <= 1'b1;
            age_q      <= '0;
            changed_q  <= !held_valid || (in != held);
            stale_q    <= stale_of('0);
        end else begin
            age_q      <= age_inc;
            changed_q  <= 1'b0;
            stale_q    <= stale_of(age_inc);
        end
    end

    if (REGISTERED != 0) begin : g_reg
        assign out          = held;
        assign status.valid = held_valid;
    end else begin : g_bypass
        assign out          = en ? in : held;
        assign status.valid = en | held_valid;
    end

    assign status.changed = changed_q;
    assign status.stale   = stale_q;
    assign age            = age_q;

endmodule

// File: rtl/enable_hold_multi.sv
// Multi-channel enable/hold: a bank of independent lanes packed onto
// flat buses, lane c at [c*WIDTH +: WIDTH].
module enable_hold_multi
    import enable_hold_pkg::*;
#(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       CHANNELS    = 4,
    parameter int unsigned       REGISTERED  = 0,
    parameter int unsigned       AGE_WIDTH   = 8,
    parameter int unsigned       STALE_LIMIT = 16,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [CHANNELS-1:0]           en,
    input  logic [CHANNELS-1:0]           clear,
    input  logic [CHANNELS*WIDTH-1:0]     in,
    output logic [CHANNELS*WIDTH-1:0]     out,
    output logic [CHANNELS-1:0]           valid,
    output logic [CHANNELS-1:0]           changed,
    output logic [CHANNELS-1:0]           stale,
    output logic [CHANNELS*AGE_WIDTH-1:0] age
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        hold_status_t st;

        enable_hold_channel #(
            .WIDTH       (WIDTH),
            .REGISTERED  (REGISTERED),
            .AGE_WIDTH   (AGE_WIDTH),
            .STALE_LIMIT (STALE_LIMIT),
            .RESET_VALUE (RESET_VALUE)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en[c]),
            .clear   (clear[c]),
            .in      (in[c*WIDTH +: WIDTH]),
            .out     (out[c*WIDTH +: WIDTH]),
            .status  (st),
            .age     (age[c*AGE_WIDTH +: AGE_WIDTH])
        );

        assign valid[c]   = st.valid;
        assign changed[c] = st.changed;
        assign stale[c]   = st.stale;
    end

endmodule

// File: tb/tb_enable_hold_multi.sv
// Bench for enable_hold_multi: three configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_enable_hold_multi;

    localparam int W = 8;
    localparam int C = 4;
    localparam int ND = 3;
    localparam int BIG = 1 << 30;

    localparam int REGP [ND] = '{0, 1, 0};
    localparam int AWP  [ND] = '{8, 8, 3};
    localparam int LIMP [ND] = '{16, 16, 5};
    localparam logic [7:0] RVP [ND] = '{8'h00, 8'hA5, 8'h3C};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  en = '0;
    logic [3:0]  clear = '0;
    logic [31:0] in = '0;

    logic [31:0] out0, out1, out2;
    logic [3:0]  valid0, valid1, valid2;
    logic [3:0]  changed0, changed1, changed2;
    logic [3:0]  stale0, stale1, stale2;
    logic [31:0] age0, age1;
    logic [11:0] age2;

    int tests = 0;
    int fails = 0;
    bit run_cmp = 1'b0;

    // Model state per DUT and lane: what was last captured and when.
    bit         hv   [ND][C];
    logic [7:0] hval [ND][C];
    int         cnt  [ND][C];
    bit         chg  [ND][C];

    always #5 clk = ~clk;

    enable_hold_multi #(.WIDTH(8), .CHANNELS(4), .REGISTERED(0),
        .AGE_WIDTH(8), .STALE_LIMIT(16), .RESET_VALUE(8'h00)) dut0 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in),
        .out(out0), .valid(valid0), .changed(changed0), .stale(stale0),
        .age(age0));

    enable_hold_multi #(.WIDTH(8), .CHANNELS(4), .REGISTERED(1),
        .AGE_WIDTH(8), .STALE_LIMIT(16), .RESET_VALUE(8'hA5)) dut1 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in),
        .out(out1), .valid(valid1), .changed(changed1), .stale(stale1),
        .age(age1));

    enable_hold_multi #(.WIDTH(8), .CHANNELS(4), .REGISTERED(0),
        .AGE_WIDTH(3), .STALE_LIMIT(5), .RESET_VALUE(8'h3C)) dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in),
        .out(out2), .valid(valid2), .changed(changed2), .stale(stale2),
        .age(age2));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < C; c++) begin
                hv[d][c]   = 1'b0;
                hval[d][c] = RVP[d];
                cnt[d][c]  = BIG;
                chg[d][c]  = 1'b0;
            end
    endtask

    // Model: a lane remembers its last capture and counts edges since.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreset();
        end else begin
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < C; c++) begin
                    if (clear[c]) begin
                        hv[d][c]   = 1'b0;
                        hval[d][c] = RVP[d];
                        cnt[d][c]  = BIG;
                        chg[d][c]  = 1'b0;
                    end else if (en[c]) begin
                        chg[d][c]  = !hv[d][c] || (in[c*8 +: 8] != hval[d][c]);
                        hv[d][c]   = 1'b1;
                        hval[d][c] = in[c*8 +: 8];
                        cnt[d][c]  = 0;
                    end else begin
                        if (cnt[d][c] < BIG) cnt[d][c] = cnt[d][c] + 1;
                        chg[d][c] = 1'b0;
                    end
                end
        end
    end

    function automatic int e_age(int d, int c);
        int mx = (1 << AWP[d]) - 1;
        return (cnt[d][c] > mx) ? mx : cnt[d][c];
    endfunction

    function automatic logic [31:0] a_out(int d, int c);
        case (d)
            0: return 32'(out0[c*8 +: 8]);
            1: return 32'(out1[c*8 +: 8]);
            default: return 32'(out2[c*8 +: 8]);
        endcase
    endfunction

    function automatic logic [3:0] a_bits(int d, int k);
        logic [3:0] v [ND][4];
        v[0][0] = valid0;   v[1][0] = valid1;   v[2][0] = valid2;
        v[0][1] = changed0; v[1][1] = changed1; v[2][1] = changed2;
        v[0][2] = stale0;   v[1][2] = stale1;   v[2][2] = stale2;
        v[0][3] = '0;       v[1][3] = '0;       v[2][3] = '0;
        return v[d][k];
    endfunction

    function automatic logic [31:0] a_age(int d, int c);
        case (d)
            0: return 32'(age0[c*8 +: 8]);
            1: return 32'(age1[c*8 +: 8]);
            default: return 32'(age2[c*3 +: 3]);
        endcase
    endfunction

    // Compare every lane of every DUT against the model each cycle.
    always @(negedge clk) begin
        if (run_cmp) begin
            for (int d = 0; d < ND; d++)
                for (int c = 0; c < C; c++) begin
                    logic [7:0] eo;
                    logic       ev;
                    logic       bp;
                    int         ea;
                    bp = (REGP[d] == 0) && en[c];
                    eo = bp ? in[c*8 +: 8] : hval[d][c];
                    ev = bp || hv[d][c];
                    ea = e_age(d, c);
                    chk($sformatf("d%0d.out%0d", d, c), a_out(d, c), 32'(eo));
                    chk($sformatf("d%0d.valid%0d", d, c),
                        32'(a_bits(d, 0)[c]), 32'(ev));
                    chk($sformatf("d%0d.changed%0d", d, c),
                        32'(a_bits(d, 1)[c]), 32'(chg[d][c]));
                    chk($sformatf("d%0d.stale%0d", d, c),
                        32'(a_bits(d, 2)[c]),
                        32'(LIMP[d] != 0 && ea >= LIMP[d]));
                    chk($sformatf("d%0d.age%0d", d, c), a_age(d, c), 32'(ea));
                end
        end
    end

    // Apply one cycle of inputs just after a posedge, return at negedge.
    task automatic drive(input logic [3:0] e, input logic [3:0] cl,
                         input logic [31:0] d);
        @(posedge clk);
        #1;
        en = e;
        clear = cl;
        in = d;
        @(negedge clk);
    endtask

    initial begin
        mreset();
        run_cmp = 1'b1;
        #12 reset_n = 1'b1;

        for (int i = 0; i < 20; i++) drive(4'h0, 4'h0, 32'h0);
        chk("rst_age0", 32'(age0[7:0]), 32'd255);
        chk("rst_stale0", 32'(stale0[0]), 32'd1);
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_out1", out1, 32'hA5A5A5A5);

        drive(4'h1, 4'h0, 32'h0000005A);
        chk("bypass_out0", 32'(out0[7:0]), 32'h5A);
        chk("reg_out0_pre", 32'(out1[7:0]), 32'hA5);
        chk("reg_valid0_pre", 32'(valid1[0]), 32'd0);
        drive(4'h0, 4'h0, 32'h0);
        chk("reg_out0_post", 32'(out1[7:0]), 32'h5A);
        chk("changed0_pulse", 32'(changed0[0]), 32'd1);
        chk("age0_zero", 32'(age0[7:0]), 32'd0);
        for (int i = 0; i < 15; i++) drive(4'h0, 4'h0, 32'h0);
        chk("age0_15", 32'(age0[7:0]), 32'd15);
        chk("stale0_15", 32'(stale0[0]), 32'd0);
        chk("age_sat3", 32'(age2[2:0]), 32'd7);
        drive(4'h0, 4'h0, 32'h0);
        chk("stale0_16", 32'(stale0[0]), 32'd1);

        drive(4'h1, 4'h0, 32'h0000005A);
        drive(4'h0, 4'h0, 32'h0);
        chk("recapture_nochg", 32'(changed1[0]), 32'd0);
        drive(4'h1, 4'h0, 32'h00000033);
        drive(4'h0, 4'h0, 32'h0);
        chk("capture33_chg", 32'(changed1[0]), 32'd1);
        drive(4'h0, 4'h0, 32'h0);
        chk("capture33_drop", 32'(changed1[0]), 32'd0);

        drive(4'h4, 4'h0, 32'h00110000);
        drive(4'h0, 4'h0, 32'h0);
        drive(4'h4, 4'h4, 32'h00FF0000);
        chk("clr_bypass_out2", 32'(out0[23:16]), 32'hFF);
        chk("clr_reg_out2", 32'(out1[23:16]), 32'h11);
        drive(4'h0, 4'h0, 32'h0);
        chk("clr_out2", 32'(out1[23:16]), 32'hA5);
        chk("clr_valid2", 32'(valid0[2]), 32'd0);
        chk("clr_age2", 32'(age0[23:16]), 32'd255);

        for (int i = 0; i < 12; i++)
            drive(4'(1 << (i % 4)), 4'h0, 32'(i * 32'h1F3B_6D97));
        for (int i = 0; i < 4; i++)
            drive(4'hF, 4'h0, 32'(i * 32'h0102_0304 + 32'h1020_3040));
        drive(4'h0, 4'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid0", 32'(valid0), 32'd0);
        chk("arst_out1", out1, 32'hA5A5A5A5);
        chk("arst_age0", age0, 32'hFFFFFFFF);
        chk("arst_age2", 32'(age2), 32'hFFF);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 10; i++)
            drive(4'((i * 5) % 16), 4'(i == 6 ? 2 : 0),
                  32'(i * 32'h2468_ACE1));
        for (int i = 0; i < 3; i++) drive(4'h0, 4'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
